// File: rtl/eth_types_pkg.sv
// Shared Ethernet receive-path types: RMII receiver state encoding and framing constants.
package eth_types_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rmii_rx_state_t;

    localparam logic [7:0] SFD_BYTE       = 8'hD5;
    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;
    localparam logic [1:0] BAD_DIBIT      = 2'b10;

endpackage

// File: rtl/rmii_rx_if.sv
// RMII receive pins plus the assembled byte stream handed to the frame parser.
interface rmii_rx_if;
    logic       crs_dv;
    logic [1:0] rxd;
    logic [7:0] received_byte;
    logic       byte_valid;
    logic       frame_end;
    logic       frame_err;

    modport master (
        input  crs_dv, rxd,
        output received_byte, byte_valid, frame_end, frame_err
    );

    modport slave (
        output crs_dv, rxd,
        input  received_byte, byte_valid, frame_end, frame_err
    );
endinterface

// File: rtl/rmii_rx.sv
// RMII receiver: turns the 2-bit RMII stream into SFD-aligned bytes with frame end/error strobes.
module rmii_rx
    import eth_types_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1530
) (
    input  logic      clk,
    input  logic      resetn,
    rmii_rx_if.master bus
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME_BYTES);

    logic       crs_dv_p1, crs_dv_p2;
    logic [1:0] rxd_p1, rxd_p2;

    rmii_rx_state_t state, state_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  byte_q, byte_nxt;
    logic [1:0]  dibit_cnt, dibit_cnt_nxt;
    logic [10:0] byte_cnt, byte_cnt_nxt;
    logic        bv_q, bv_nxt;
    logic        fe_q, fe_nxt;
    logic        ferr_q, ferr_nxt;
    logic        live;

    // Stage p1/p2: pin capture plus one cycle of crs_dv lookahead
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crs_dv_p1 <= 1'b0;
            rxd_p1    <= 2'b00;
            crs_dv_p2 <= 1'b0;
            rxd_p2    <= 2'b00;
        end else begin
            crs_dv_p1 <= bus.crs_dv;
            rxd_p1    <= bus.rxd;
            crs_dv_p2 <= crs_dv_p1;
            rxd_p2    <= rxd_p1;
        end
    end

    // A lone low crs_dv cycle is the PHY toggling at end of frame, not loss of carrier
    assign live = crs_dv_p2 | crs_dv_p1;

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        byte_nxt      = byte_q;
        dibit_cnt_nxt = dibit_cnt;
        byte_cnt_nxt  = byte_cnt;
        bv_nxt        = 1'b0;
        fe_nxt        = 1'b0;
        ferr_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (live && rxd_p2 == PREAMBLE_DIBIT) state_nxt = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!live || rxd_p2 == BAD_DIBIT) begin
                    state_nxt = ST_IDLE;
                end else if (rxd_p2 == SFD_LAST_DIBIT) begin
                    byte_nxt      = SFD_BYTE;
                    bv_nxt        = 1'b1;
                    dibit_cnt_nxt = 2'd0;
                    byte_cnt_nxt  = 11'd0;
                    state_nxt     = ST_DATA;
                end
            end
            ST_DATA: begin
                // Oversize takes priority: the limit byte has already gone out
                if (byte_cnt == MAX_CNT) begin
                    fe_nxt    = 1'b1;
                    ferr_nxt  = 1'b1;
                    state_nxt = ST_DROP;
                end else if (!live) begin
                    fe_nxt    = 1'b1;
                    ferr_nxt  = (dibit_cnt != 2'd0);
                    state_nxt = ST_IDLE;
                end else begin
                    shreg_nxt     = {rxd_p2, shreg[7:2]};
                    dibit_cnt_nxt = dibit_cnt + 2'd1;
                    if (dibit_cnt == 2'd3) begin
                        byte_nxt     = {rxd_p2, shreg[7:2]};
                        bv_nxt       = 1'b1;
                        byte_cnt_nxt = byte_cnt + 11'd1;
                    end
                end
            end
            ST_DROP: begin
                if (!live) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            shreg     <= 8'h00;
            byte_q    <= 8'h00;
            dibit_cnt <= 2'd0;
            byte_cnt  <= 11'd0;
            bv_q      <= 1'b0;
            fe_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            byte_q    <= byte_nxt;
            dibit_cnt <= dibit_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
            bv_q      <= bv_nxt;
            fe_q      <= fe_nxt;
            ferr_q    <= ferr_nxt;
        end
    end

    assign bus.received_byte = byte_q;
    assign bus.byte_valid    = bv_q;
    assign bus.frame_end     = fe_q;
    assign bus.frame_err     = ferr_q;

endmodule

// File: tb/tb_rmii_rx.sv
// Bench for rmii_rx: two instances (default and 16-byte limit) share one dibit stream; event
// streams are compared against a burst-level frame decoder.
module tb_rmii_rx;

    localparam int SMALL_MAX = 16;

    logic clk = 1'b0;
    logic resetn;
    always #10 clk = ~clk;

    rmii_rx_if bus_a ();
    rmii_rx_if bus_b ();

    rmii_rx u_dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
    rmii_rx #(.MAX_FRAME_BYTES(SMALL_MAX)) u_dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int d5_cyc = 0;
    int mark_idx;
    int mark_edge;
    int viol[2] = '{0, 0};
    int vbase[2];

    logic       st_crs[$];
    logic [1:0] st_dib[$];
    logic [1:0] bq[$];
    // Events: 0..255 byte strobe, 256 clean frame_end, 257 frame_end with frame_err
    int exp_q[2][$];
    int got_q[2][$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bus_a.byte_valid === 1'b1) begin
                if (got_q[0].size() == 0) d5_cyc <= cyc;
                got_q[0].push_back(int'(bus_a.received_byte));
            end
            if (bus_a.frame_end === 1'b1) got_q[0].push_back(256 + int'(bus_a.frame_err));
            if ((bus_a.byte_valid && bus_a.frame_end) || (bus_a.frame_err && !bus_a.frame_end))
                viol[0] <= viol[0] + 1;
            if (bus_b.byte_valid === 1'b1) got_q[1].push_back(int'(bus_b.received_byte));
            if (bus_b.frame_end === 1'b1) got_q[1].push_back(256 + int'(bus_b.frame_err));
            if ((bus_b.byte_valid && bus_b.frame_end) || (bus_b.frame_err && !bus_b.frame_end))
                viol[1] <= viol[1] + 1;
        end
    end

    function automatic int maxb(input int d);
        return (d == 0) ? 1530 : SMALL_MAX;
    endfunction

    function automatic bit is_live(input int i);
        return st_crs[i] || ((i + 1 < st_crs.size()) && st_crs[i + 1]);
    endfunction

    task automatic clear_run();
        st_crs.delete();
        st_dib.delete();
        mark_idx = -1;
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            got_q[d].delete();
            vbase[d] = viol[d];
        end
    endtask

    task automatic push_dibit(input logic c, input logic [1:0] v);
        st_crs.push_back(c);
        st_dib.push_back(v);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push_dibit(1'b0, 2'b00);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit toggle);
        for (int k = 0; k < 4; k++) push_dibit(toggle ? (k % 2 == 1) : 1'b1, b[2*k +: 2]);
    endtask

    task automatic push_header(input int npre);
        repeat (npre) push_byte(8'h55, 1'b0);
        push_byte(8'hD5, 1'b0);
        mark_idx = st_dib.size() - 1;
    endtask

    // Reference: find the SFD inside one carrier burst, then slice whole bytes after it
    task automatic decode_burst();
        int m, k, sfd, rest, nb, lim;
        m = bq.size();
        k = 0;
        sfd = -1;
        while (k < m && sfd < 0) begin
            while (k < m && bq[k] != 2'b01) k++;
            if (k >= m) break;
            k++;
            while (k < m && bq[k][1] == 1'b0) k++;
            if (k >= m) break;
            if (bq[k] == 2'b11) sfd = k;
            else k++;
        end
        if (sfd < 0) return;
        rest = m - sfd - 1;
        nb = rest / 4;
        for (int d = 0; d < 2; d++) begin
            exp_q[d].push_back(8'hD5);
            lim = (nb >= maxb(d)) ? maxb(d) : nb;
            for (int j = 0; j < lim; j++)
                exp_q[d].push_back(int'(bq[sfd+1+4*j]) + 4 * int'(bq[sfd+2+4*j]) +
                                   16 * int'(bq[sfd+3+4*j]) + 64 * int'(bq[sfd+4+4*j]));
            exp_q[d].push_back((nb >= maxb(d) || rest % 4 != 0) ? 257 : 256);
        end
    endtask

    task automatic build_expected();
        int i, n;
        n = st_dib.size();
        i = 0;
        while (i < n) begin
            if (!is_live(i)) begin
                i++;
                continue;
            end
            bq.delete();
            while (i < n && is_live(i)) begin
                bq.push_back(st_dib[i]);
                i++;
            end
            decode_burst();
        end
    endtask

    task automatic set_pins(input logic c, input logic [1:0] v);
        bus_a.crs_dv = c;
        bus_a.rxd    = v;
        bus_b.crs_dv = c;
        bus_b.rxd    = v;
    endtask

    task automatic run_stim(input int tail_idle);
        for (int i = 0; i < st_dib.size(); i++) begin
            @(negedge clk);
            set_pins(st_crs[i], st_dib[i]);
            if (i == mark_idx) mark_edge = cyc + 1;
        end
        repeat (tail_idle) begin
            @(negedge clk);
            set_pins(1'b0, 2'b00);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_pins(1'b1, (i < 5) ? 2'b01 : 2'b11);
        end
        #1;
        n_checks++;
        if (bus_a.received_byte !== 8'h00 || bus_a.byte_valid !== 1'b0 ||
            bus_a.frame_end !== 1'b0 || bus_a.frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_a: got byte=%h bv=%b fe=%b ferr=%b, expected all zero",
                     bus_a.received_byte, bus_a.byte_valid, bus_a.frame_end, bus_a.frame_err);
        end
        n_checks++;
        if (bus_b.received_byte !== 8'h00 || bus_b.byte_valid !== 1'b0 ||
            bus_b.frame_end !== 1'b0 || bus_b.frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_b: got byte=%h bv=%b fe=%b ferr=%b, expected all zero",
                     bus_b.received_byte, bus_b.byte_valid, bus_b.frame_end, bus_b.frame_err);
        end
        @(negedge clk);
        set_pins(1'b0, 2'b00);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_run();
        push_idle(4);
        push_header(7);
        foreach (st_crs[i]) ;
        push_byte(8'h00, 0); push_byte(8'h1A, 0); push_byte(8'h2B, 0);
        push_byte(8'h3C, 0); push_byte(8'h4D, 0); push_byte(8'h5E, 0);
        build_expected();
        run_stim(10);
        n_checks++;
        if (d5_cyc !== mark_edge + 2) begin
            n_errors++;
            $display("FAIL basic_latency: SFD strobe at cycle %0d, expected %0d", d5_cyc, mark_edge + 2);
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL basic_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL basic_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_toggle();
        clear_run();
        push_idle(4);
        push_header(7);
        push_byte(8'h00, 0); push_byte(8'h1A, 0); push_byte(8'h2B, 0);
        push_byte(8'h3C, 0); push_byte(8'h4D, 1); push_byte(8'h5E, 1);
        build_expected();
        run_stim(10);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL toggle_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL toggle_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_partial();
        clear_run();
        push_idle(4);
        push_header(7);
        push_byte(8'h00, 0); push_byte(8'h1A, 0);
        push_dibit(1'b1, 2'b11); push_dibit(1'b1, 2'b10);
        build_expected();
        run_stim(10);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL partial_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL partial_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_oversize();
        clear_run();
        push_idle(4);
        push_header(7);
        for (int j = 0; j < 20; j++) push_byte(8'(8'h30 + j), 0);
        build_expected();
        run_stim(12);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL oversize_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL oversize_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_bad_preamble();
        clear_run();
        push_idle(4);
        repeat (3) push_byte(8'h55, 0);
        push_dibit(1, 2'b01); push_dibit(1, 2'b01); push_dibit(1, 2'b01);
        push_dibit(1, 2'b10); push_dibit(1, 2'b11);
        push_byte(8'h00, 0); push_byte(8'hAA, 0); push_byte(8'hFF, 0);
        push_idle(6);
        push_header(7);
        push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0);
        build_expected();
        run_stim(10);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL badpre_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL badpre_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_run();
        push_idle(4);
        push_header(3);
        repeat (5) push_byte(8'($urandom), 0);
        push_idle(2);
        push_header(2);
        repeat (4) push_byte(8'($urandom), 0);
        build_expected();
        run_stim(10);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL b2b_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL b2b_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        clear_run();
        push_idle(4);
        push_header(7);
        push_byte(8'h00, 0); push_byte(8'h1A, 0); push_byte(8'h2B, 0);
        push_dibit(1, 2'b00); push_dibit(1, 2'b11); push_dibit(1, 2'b11);
        build_expected();
        // The carrier is cut by reset, so the decoder's closing frame_end must never appear
        for (int d = 0; d < 2; d++) void'(exp_q[d].pop_back());
        run_stim(0);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        set_pins(1'b0, 2'b00);
        #1;
        n_checks++;
        if (bus_a.received_byte !== 8'h00 || bus_a.byte_valid !== 1'b0 ||
            bus_b.received_byte !== 8'h00 || bus_b.byte_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_out: got a=%h/%b b=%h/%b, expected 00/0",
                     bus_a.received_byte, bus_a.byte_valid, bus_b.received_byte, bus_b.byte_valid);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL midreset_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL midreset_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
        clear_run();
        push_idle(2);
        push_header(7);
        push_byte(8'hC0, 0); push_byte(8'hFF, 0); push_byte(8'hEE, 0); push_byte(8'h01, 0);
        build_expected();
        run_stim(10);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL postreset_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL postreset_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        bit tog;
        clear_run();
        for (int f = 0; f < 10; f++) begin
            push_idle(3 + $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) push_dibit(1'b1, 2'b00);
            push_header($urandom_range(1, 7));
            len = $urandom_range(0, 22);
            tog = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) push_byte(8'($urandom), tog && (j >= len - 2));
            repeat ($urandom_range(0, 3)) push_dibit(1'b1, 2'($urandom));
        end
        build_expected();
        run_stim(12);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_q[d].size() !== exp_q[d].size() || viol[d] != vbase[d]) begin
                n_errors++;
                $display("FAIL random_len[%0d]: got %0d events (%0d overlaps), expected %0d (0)",
                         d, got_q[d].size(), viol[d] - vbase[d], exp_q[d].size());
            end
            for (int i = 0; i < exp_q[d].size(); i++) begin
                n_checks++;
                if (i >= got_q[d].size() || got_q[d][i] !== exp_q[d][i]) begin
                    n_errors++;
                    $display("FAIL random_ev[%0d][%0d]: got %0d expected %0d", d, i,
                             (i < got_q[d].size()) ? got_q[d][i] : -1, exp_q[d][i]);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        set_pins(1'b0, 2'b00);
        test_reset();
        test_basic();
        test_toggle();
        test_partial();
        test_oversize();
        test_bad_preamble();
        test_back_to_back();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
